tty_fifo_ka10: RTL and testbench
================================

// Module: tty_fifo_ka10
// PURPOSE
//  Parametrised KA10 console TTY on the IO bus, successor of the single-char TTY.
//  Programmable device code, bit time, frame format and RX FIFO depth.
//  UART-framed TX/RX with mid-bit sampling; RX overrun is detected.
//  Drives the PI request lines and the panel status lamps.
// PARAMETERS
//  DEVCODE    7'b001_010_0  device select, compared against iobus_ios[3:9]
//  BIT_CLKS   454545        clk cycles per bit (110 baud @ 50 MHz); must be >= 4
//  DATA_BITS  8             5..8, sent and received LSB first
//  STOP_BITS  2             1 or 2
//  RX_DEPTH   4             RX FIFO entries; power of 2, >= 2
// PORTS
//  clk                 in   1   system clock
//  reset               in   1   async, active-high; clears all state
//  iobus_iob_reset     in   1   bus reset level
//  iobus_datao_clear   in   1   DATAO clear strobe (level)
//  iobus_datao_set     in   1   DATAO set strobe (level)
//  iobus_cono_clear    in   1   CONO clear strobe (level)
//  iobus_cono_set      in   1   CONO set strobe (level)
//  iobus_iob_fm_datai  in   1   DATAI read enable
//  iobus_iob_fm_status in   1   CONI read enable
//  iobus_ios           in   7   [3:9] device select
//  iobus_iob_in        in   36  [0:35] bus data in
//  iobus_pi_req        out  7   [1:7] PI request
//  iobus_iob_out       out  36  [0:35] bus data out; 0 when not selected
//  rx                  in   1   serial in, idle high
//  tx                  out  1   serial out, idle high
//  status_ind          out  12  {test,ovr,brk,rx_act,tx_act,ti_busy,ti_flag,to_busy,to_flag,pia[3]}
// BEHAVIOUR
//  - Reset values: tx=1, pi_req=0, iob_out=0, all flags/pia/test=0, FIFO empty, FSMs IDLE.
//  - All strobes: rising edge gated by sel, acted on exactly once, one cycle after the edge.
//    iob_reset edge = reset for flags, FIFO and FSMs, plus CONO clear.
//  - CONO clear: pia=0, test=0. CONO set, in[n]: 10/14 clr/set to_flag,
//    9/13 to_busy, 8/12 ti_flag, 7/11 ti_busy, 6 set test, 5 clr ovr, 4 clr brk;
//    pia |= in[15:17].
//  - DATAO clear: to_busy=1, to_flag=0. DATAO set: latch in[36-DATA_BITS:35] into TX holding reg.
//  - TX FSM IDLE->START->DATA(DATA_BITS)->STOP(STOP_BITS)->IDLE; each state BIT_CLKS cycles.
//    Leaves IDLE on the cycle after DATAO set. On STOP->IDLE: to_busy=0, to_flag=1.
//    DATAO set while not IDLE replaces the holding reg and is sent after the current frame.
//  - RX: idle-high line through 2-flop sync. Input = tx line when test=1, else rx.
//    Falling edge in IDLE -> wait BIT_CLKS/2. Start bit low: enter frame, ti_busy=1.
//    Start bit high: glitch, back to IDLE, nothing pushed.
//    Sample data bits and stop bit(s) every BIT_CLKS. Good stop: push char, ti_busy=0.
//  - FIFO: ti_flag = !empty, recomputed each cycle; CONO set 12 forces it only until next update.
//    Push when full: drop the char, ovr=1.
//  - DATAI: iob_out = {zeros, head char}. Pop on DATAI falling edge.
//    Pop on empty FIFO: no-op, reads 0. Push and pop in the same cycle: both take effect.
//  - CONI word: bit24 test, 25 ovr, 26 brk, 29 ti_busy, 30 ti_flag, 31 to_busy,
//    32 to_flag, 33:35 pia; other bits 0.
//  - pi_req: bit[pia] = ti_flag|to_flag when pia!=0; all 0 when pia==0.
//  - Reset/iob_reset mid-frame: FSMs abort to IDLE, tx=1 next cycle, no flag set.
// CONFIGURATION
//  TTY_BREAK_DET_EN defined:
//  - A frame whose data and stop bits are all 0 sets brk=1 and is not pushed.
//  - RX then stays IDLE until rx has been high for one full bit time.
//  Not defined:
//  - brk reads 0. Such a frame is a framing error: char dropped, no flag change.
// TESTING
//  1. Reset; CONO set pia=3, in[14]=1 -> to_flag=1, pi_req=7'b0010000; CONI=...0_001_011 (to_flag,pia=3).
//  2. DATAO 8'o101, 8N2 -> tx low 1 bit, bits 1,0,0,0,0,0,1,0, high 2 bits; then to_flag=1, to_busy=0.
//  3. test=1; DATAO 8'o123 -> ti_flag=1; DATAI returns 36'o123; ti_flag=0 after DATAI falls.
//  4. RX_DEPTH=4; send 5 chars with no DATAI -> 4 read back in order; ovr=1; CONO in[5] clears it.
//  5. rx low for BIT_CLKS/4 then high -> no push, ti_busy returns 0, ti_flag stays 0.
//  6. Assert reset mid-TX data bit -> tx=1, to_flag=0; with TTY_BREAK_DET_EN, 12-bit low on rx -> brk=1, FIFO empty.

Source files
------------

// File: rtl/tty_fifo_ka10.sv
// KA10 console TTY on the IO bus: UART TX, mid-bit sampling RX with RX FIFO, CONO/CONI/DATAO/DATAI.
// Define TTY_BREAK_DET_EN to enable RX break detection (brk status bit).
module tty_fifo_ka10 #(
    parameter logic [6:0]  DEVCODE   = 7'b001_010_0,
    parameter int unsigned BIT_CLKS  = 454545,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 2,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_reset,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_fm_datai,
    input  logic        iobus_iob_fm_status,
    input  logic [3:9]  iobus_ios,
    input  logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi_req,
    output logic [0:35] iobus_iob_out,
    input  logic        rx,
    output logic        tx,
    output logic [11:0] status_ind
);
    localparam int unsigned CW   = $clog2(BIT_CLKS + 1);
    localparam int unsigned AW   = $clog2(RX_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);

    logic sel;
    logic [5:0] lv, lv_q;
    logic bus_rst, datao_clr_edge, datao_set_edge, cono_clr_edge, cono_set_edge, pop_req;

    logic to_flag, to_busy, ti_flag, ti_busy, ovr, brk, test;
    logic [2:0] pia;

    assign sel = (iobus_ios == DEVCODE);
    assign lv  = {iobus_iob_reset, iobus_datao_clear, iobus_datao_set,
                  iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lv_q <= '0;
        else       lv_q <= lv;
    end

    // Bus reset is a system-wide level and is deliberately not gated by device select.
    assign bus_rst        = lv[5] & ~lv_q[5];
    assign datao_clr_edge = sel & lv[4] & ~lv_q[4];
    assign datao_set_edge = sel & lv[3] & ~lv_q[3];
    assign cono_clr_edge  = sel & lv[2] & ~lv_q[2];
    assign cono_set_edge  = sel & lv[1] & ~lv_q[1];
    assign pop_req        = sel & ~lv[0] & lv_q[0];

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [DATA_BITS-1:0] tx_hold, tx_shift;
    logic tx_pend, tx_tick, tx_load, tx_done;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_done = 1'b0;
        unique case (tx_state)
            TX_IDLE:  if (tx_pend) begin tx_next = TX_START; tx_load = 1'b1; end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'(DATA_BITS - 1)) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick && tx_bit == 3'(STOP_BITS - 1)) begin
                          tx_next = TX_IDLE;
                          tx_done = 1'b1;
                      end
            default:  tx_next = TX_IDLE;
        endcase
        if (bus_rst) begin
            tx_next = TX_IDLE;
            tx_load = 1'b0;
            tx_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_hold  <= '0;
            tx_shift <= '0;
            tx_pend  <= 1'b0;
        end else if (bus_rst) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_pend <= 1'b0;
        end else begin
            if (tx_next != tx_state || tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
            end else if (tx_tick) begin
                tx_cnt <= '0;
                tx_bit <= tx_bit + 3'd1;
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
            if (tx_load) begin
                tx_shift <= tx_hold;
                tx_pend  <= 1'b0;
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
            end
            // A later DATAO set overrides the holding register and re-arms the send.
            if (datao_set_edge) begin
                tx_hold <= iobus_iob_in[36-DATA_BITS:35];
                tx_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        if (tx_state == TX_START)     tx = 1'b0;
        else if (tx_state == TX_DATA) tx = tx_shift[0];
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;
    rx_state_t rx_state, rx_next;
    logic [1:0] rx_sync;
    logic rx_prev, rx_s, rx_fall, rx_in;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic rx_stop_ok, rx_any_one, rx_sample;
    logic rx_push, rx_brk_set, rx_frame_on, rx_frame_end;

    assign rx_in     = test ? tx : rx;
    assign rx_s      = rx_sync[1];
    assign rx_fall   = rx_prev & ~rx_s;
    assign rx_sample = (rx_cnt == BIT_LAST);

    always_comb begin
        rx_next      = rx_state;
        rx_push      = 1'b0;
        rx_brk_set   = 1'b0;
        rx_frame_on  = 1'b0;
        rx_frame_end = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) begin
                          if (!rx_s) begin rx_next = RX_DATA; rx_frame_on = 1'b1; end
                          else rx_next = RX_IDLE;
                      end
            RX_DATA:  if (rx_sample && rx_bit == 3'(DATA_BITS - 1)) rx_next = RX_STOP;
            RX_STOP:  if (rx_sample && rx_bit == 3'(STOP_BITS - 1)) begin
                          rx_next      = RX_IDLE;
                          rx_frame_end = 1'b1;
                          if (rx_stop_ok && rx_s) rx_push = 1'b1;
`ifdef TTY_BREAK_DET_EN
                          else if (!(rx_any_one || rx_s)) begin
                              rx_brk_set = 1'b1;
                              rx_next    = RX_BRK;
                          end
`endif
                      end
            RX_BRK:   if (rx_s && rx_sample) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
        if (bus_rst) begin
            rx_next      = RX_IDLE;
            rx_push      = 1'b0;
            rx_brk_set   = 1'b0;
            rx_frame_on  = 1'b0;
            rx_frame_end = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync    <= '1;
            rx_prev    <= 1'b1;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_stop_ok <= 1'b0;
            rx_any_one <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx_in};
            rx_prev <= rx_s;
            if (rx_next != rx_state || rx_state == RX_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
            end else if (rx_state == RX_BRK) begin
                rx_cnt <= rx_s ? rx_cnt + CW'(1) : '0;
            end else if (rx_sample) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 3'd1;
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
            if (rx_frame_on) begin
                rx_stop_ok <= 1'b1;
                rx_any_one <= 1'b0;
            end
            if (rx_state == RX_DATA && rx_sample) begin
                rx_shift   <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_any_one <= rx_any_one | rx_s;
            end
            if (rx_state == RX_STOP && rx_sample) begin
                rx_stop_ok <= rx_stop_ok & rx_s;
                rx_any_one <= rx_any_one | rx_s;
            end
        end
    end

    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CNTW-1:0] count, count_next;
    logic empty, full, do_pop, do_push, drop;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(RX_DEPTH));
    assign do_pop  = pop_req & ~empty;
    assign do_push = rx_push & (~full | do_pop);
    assign drop    = rx_push & full & ~do_pop;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)      count_next = count + CNTW'(1);
        else if (do_pop && !do_push) count_next = count - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= rx_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (bus_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_flag <= 1'b0;
            to_busy <= 1'b0;
            ti_flag <= 1'b0;
            ti_busy <= 1'b0;
            ovr     <= 1'b0;
            test    <= 1'b0;
            pia     <= '0;
        end else if (bus_rst) begin
            to_flag <= 1'b0;
            to_busy <= 1'b0;
            ti_flag <= 1'b0;
            ti_busy <= 1'b0;
            ovr     <= 1'b0;
            test    <= 1'b0;
            pia     <= '0;
        end else begin
            // ti_flag tracks FIFO occupancy; a CONO force below holds only for one cycle.
            ti_flag <= (count_next != '0);
            if (rx_frame_on)  ti_busy <= 1'b1;
            if (rx_frame_end) ti_busy <= 1'b0;
            if (drop)         ovr <= 1'b1;
            if (tx_done) begin
                to_busy <= 1'b0;
                to_flag <= 1'b1;
            end
            if (cono_clr_edge) begin
                pia  <= '0;
                test <= 1'b0;
            end
            if (cono_set_edge) begin
                if (iobus_iob_in[10]) to_flag <= 1'b0;
                if (iobus_iob_in[14]) to_flag <= 1'b1;
                if (iobus_iob_in[9])  to_busy <= 1'b0;
                if (iobus_iob_in[13]) to_busy <= 1'b1;
                if (iobus_iob_in[8])  ti_flag <= 1'b0;
                if (iobus_iob_in[12]) ti_flag <= 1'b1;
                if (iobus_iob_in[7])  ti_busy <= 1'b0;
                if (iobus_iob_in[11]) ti_busy <= 1'b1;
                if (iobus_iob_in[6])  test    <= 1'b1;
                if (iobus_iob_in[5])  ovr     <= 1'b0;
                pia <= (cono_clr_edge ? 3'b000 : pia) | iobus_iob_in[15:17];
            end
            if (datao_clr_edge) begin
                to_busy <= 1'b1;
                to_flag <= 1'b0;
            end
        end
    end

`ifdef TTY_BREAK_DET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  brk <= 1'b0;
        else if (bus_rst)                           brk <= 1'b0;
        else if (rx_brk_set)                        brk <= 1'b1;
        else if (cono_set_edge && iobus_iob_in[4])  brk <= 1'b0;
    end
`else
    assign brk = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{iobus_iob_in, rx_brk_set};

    always_comb begin
        iobus_pi_req = '0;
        if (pia != 3'd0) iobus_pi_req[pia] = ti_flag | to_flag;
    end

    always_comb begin
        iobus_iob_out = '0;
        if (sel && iobus_iob_fm_status) begin
            iobus_iob_out[24]    = test;
            iobus_iob_out[25]    = ovr;
            iobus_iob_out[26]    = brk;
            iobus_iob_out[29]    = ti_busy;
            iobus_iob_out[30]    = ti_flag;
            iobus_iob_out[31]    = to_busy;
            iobus_iob_out[32]    = to_flag;
            iobus_iob_out[33:35] = pia;
        end
        if (sel && iobus_iob_fm_datai && !empty)
            iobus_iob_out[36-DATA_BITS:35] = iobus_iob_out[36-DATA_BITS:35] | mem[rptr];
    end

    assign status_ind = {test, ovr, brk, rx_state != RX_IDLE, tx_state != TX_IDLE,
                         ti_busy, ti_flag, to_busy, to_flag, pia};
endmodule

// File: tb/tb_tty_fifo_ka10.sv
// Directed bench for tty_fifo_ka10: CONO/CONI, TX framing, loopback RX, FIFO overrun, glitch, resets, break.
module tb_tty_fifo_ka10;
    localparam int unsigned BIT = 16;
    localparam logic [6:0] DEV = 7'b001_010_0;

    logic clk = 1'b0, reset = 1'b1, iob_reset = 1'b0;
    logic datao_clear = 1'b0, datao_set = 1'b0, cono_clear = 1'b0, cono_set = 1'b0;
    logic fm_datai = 1'b0, fm_status = 1'b0, rx = 1'b1;
    logic [3:9]  ios = DEV;
    logic [0:35] iob_in = '0;
    logic [1:7]  pi_req;
    logic [0:35] iob_out;
    logic        tx;
    logic [11:0] status_ind;

    int unsigned checks = 0, failures = 0;
    logic [0:35] w;
    logic [35:0] v;
    logic [7:0]  got_byte;

    always #5 clk = ~clk;

    tty_fifo_ka10 #(
        .DEVCODE(DEV), .BIT_CLKS(BIT), .DATA_BITS(8), .STOP_BITS(2), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .iobus_iob_reset(iob_reset),
        .iobus_datao_clear(datao_clear), .iobus_datao_set(datao_set),
        .iobus_cono_clear(cono_clear), .iobus_cono_set(cono_set),
        .iobus_iob_fm_datai(fm_datai), .iobus_iob_fm_status(fm_status),
        .iobus_ios(ios), .iobus_iob_in(iob_in), .iobus_pi_req(pi_req),
        .iobus_iob_out(iob_out), .rx(rx), .tx(tx), .status_ind(status_ind)
    );

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // which: 0 CONO clear, 1 CONO set, 2 DATAO clear, 3 DATAO set
    task automatic pulse(input int unsigned which, input logic [0:35] d);
        @(negedge clk);
        iob_in = d;
        case (which)
            0: cono_clear = 1'b1;
            1: cono_set = 1'b1;
            2: datao_clear = 1'b1;
            default: datao_set = 1'b1;
        endcase
        @(negedge clk);
        cono_clear = 1'b0; cono_set = 1'b0; datao_clear = 1'b0; datao_set = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_bus(input logic is_status, output logic [35:0] val);
        @(negedge clk);
        if (is_status) fm_status = 1'b1;
        else           fm_datai = 1'b1;
        @(negedge clk);
        val = iob_out;
        fm_status = 1'b0;
        fm_datai = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_bit(input string tag, input int idx, input logic val, input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc && status_ind[idx] !== val; i++) @(negedge clk);
        check(tag, 36'(status_ind[idx]), 36'(val));
    endtask

    task automatic wait_tx_low(input string tag);
        for (int unsigned i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        check(tag, 36'(tx), 36'(1'b0));
    endtask

    task automatic send_char(input logic [7:0] c);
        logic [0:35] d;
        pulse(2, '0);
        d = '0;
        d[28:35] = c;
        pulse(3, d);
        wait_bit("send_done", 3, 1'b1, 14 * BIT);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx", 36'(tx), 36'(1'b1));
        check("rst_status", 36'(status_ind), 36'h0);
        check("rst_pireq", 36'(pi_req), 36'h0);
        read_bus(1'b1, v);
        check("rst_coni", v, 36'h0);

        // CONO: set to_flag, pia=3
        w = '0; w[14] = 1'b1; w[15:17] = 3'd3;
        pulse(1, w);
        check("cono_status", 36'(status_ind), 36'h00B);
        check("cono_pireq", 36'(pi_req), 36'(7'b0010000));
        read_bus(1'b1, v);
        check("coni_word", v, 36'o13);
        ios = 7'b0000001;
        fm_status = 1'b1;
        @(negedge clk);
        v = iob_out;
        check("deselect_out", v, 36'h0);
        fm_status = 1'b0;
        ios = DEV;

        // TX framing of 8'o101
        pulse(2, '0);
        check("datao_clr_status", 36'(status_ind), 36'h013);
        check("datao_clr_pireq", 36'(pi_req), 36'h0);
        w = '0; w[28:35] = 8'o101;
        pulse(3, w);
        wait_tx_low("tx_start_edge");
        repeat (BIT / 2) @(negedge clk);
        check("tx_start_bit", 36'(tx), 36'(1'b0));
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            got_byte[i] = tx;
        end
        check("tx_data", 36'(got_byte), 36'o101);
        for (int i = 0; i < 2; i++) begin
            repeat (BIT) @(negedge clk);
            check("tx_stop", 36'(tx), 36'(1'b1));
        end
        wait_bit("tx_done", 3, 1'b1, 2 * BIT);
        check("tx_done_status", 36'(status_ind), 36'h00B);
        check("tx_done_pireq", 36'(pi_req), 36'(7'b0010000));

        // Loopback via test mode
        w = '0; w[6] = 1'b1;
        pulse(1, w);
        check("test_set", 36'(status_ind), 36'h80B);
        w = '0; w[28:35] = 8'o123;
        pulse(3, w);
        wait_bit("lb_ti_flag", 5, 1'b1, 14 * BIT);
        read_bus(1'b0, v);
        check("lb_datai", v, 36'o123);
        check("lb_ti_flag_clr", 36'(status_ind[5]), 36'(1'b0));
        wait_bit("lb_tx_idle", 7, 1'b0, 2 * BIT);
        check("lb_status", 36'(status_ind), 36'h80B);

        // Overrun: 5 chars into 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_char(8'(i));
        check("ovr_status", 36'(status_ind), 36'hC2B);
        for (int i = 1; i <= 4; i++) begin
            read_bus(1'b0, v);
            check("fifo_rd", v, 36'(i));
        end
        read_bus(1'b0, v);
        check("fifo_rd_empty", v, 36'h0);
        check("fifo_drained", 36'(status_ind), 36'hC0B);
        w = '0; w[5] = 1'b1;
        pulse(1, w);
        check("ovr_clr", 36'(status_ind), 36'h80B);
        pulse(0, '0);
        check("cono_clear", 36'(status_ind), 36'h008);
        check("cono_clear_pireq", 36'(pi_req), 36'h0);

        // Start-bit glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_rx_act", 36'(status_ind[8]), 36'(1'b1));
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_status", 36'(status_ind), 36'h008);

        // Bus reset mid-frame
        w = '0; w[28:35] = 8'o101;
        pulse(3, w);
        wait_tx_low("iorst_tx_start");
        repeat (BIT / 2 + 2 * BIT) @(negedge clk);
        check("iorst_mid_bit", 36'(tx), 36'(1'b0));
        iob_reset = 1'b1;
        @(negedge clk);
        iob_reset = 1'b0;
        @(negedge clk);
        check("iorst_tx", 36'(tx), 36'(1'b1));
        check("iorst_status", 36'(status_ind), 36'h0);

        // Async reset mid-frame
        w = '0; w[14] = 1'b1;
        pulse(1, w);
        check("to_flag_preset", 36'(status_ind), 36'h008);
        w = '0; w[28:35] = 8'o101;
        pulse(3, w);
        wait_tx_low("rst_tx_start");
        repeat (BIT / 2 + 2 * BIT) @(negedge clk);
        check("rst_mid_bit", 36'(tx), 36'(1'b0));
        reset = 1'b1;
        #1;
        check("rst_async_tx", 36'(tx), 36'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_status", 36'(status_ind), 36'h0);
        repeat (2 * BIT) @(negedge clk);
        check("rst_no_resume_tx", 36'(tx), 36'(1'b1));
        check("rst_no_resume_st", 36'(status_ind), 36'h0);

        // 12-bit-time low on rx
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
`ifdef TTY_BREAK_DET_EN
        check("break_status", 36'(status_ind), 36'h200);
`else
        check("break_status", 36'(status_ind), 36'h000);
`endif
        read_bus(1'b0, v);
        check("break_fifo_empty", v, 36'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
